// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one multiply/divide unit between two issue requesters.
// Round-robin picks which requester issues. An owner table indexed by trans_id
// sends each result back to the requester that issued it, so results may come
// back in a different order from the one they were issued in.
module mult_share_arb #(
    parameter int XLEN          = 64,
    parameter int OP_BITS       = 7,
    parameter int TRANS_ID_BITS = 3,
    parameter int MAX_OUTST     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [1:0]                    req_valid_i,
    output logic [1:0]                    req_ready_o,
    input  logic [1:0][OP_BITS-1:0]       req_op_i,
    input  logic [1:0][XLEN-1:0]          req_a_i,
    input  logic [1:0][XLEN-1:0]          req_b_i,
    input  logic [1:0][TRANS_ID_BITS-1:0] req_tid_i,
    output logic                          mult_valid_o,
    input  logic                          mult_ready_i,
    output logic [OP_BITS-1:0]            mult_op_o,
    output logic [XLEN-1:0]               mult_a_o,
    output logic [XLEN-1:0]               mult_b_o,
    output logic [TRANS_ID_BITS-1:0]      mult_tid_o,
    input  logic                          mult_valid_i,
    input  logic [XLEN-1:0]               mult_result_i,
    input  logic [TRANS_ID_BITS-1:0]      mult_tid_i,
    output logic [1:0]                    res_valid_o,
    output logic [XLEN-1:0]               res_data_o,
    output logic [TRANS_ID_BITS-1:0]      res_tid_o,
    output logic                          stray_o
);

    localparam int DEPTH = 2 ** TRANS_ID_BITS;
    localparam int CW    = $clog2(MAX_OUTST + 1);

    logic [DEPTH-1:0]   busy_q;
    logic [DEPTH-1:0]   owner_q;
    logic [1:0][CW-1:0] outst_q;
    logic               last_q;
    logic               stray_q;

    logic [1:0] eligible;
    logic       winner;
    logic       issue;
    logic       ret_hit;
    logic       ret_owner;
    logic [1:0] inc;
    logic [1:0] dec;

    // A requester may issue only if it is under its in-flight limit and its
    // trans_id is free. Nothing is offered during flush or reset, so the
    // outputs read as idle while reset is held.
    always_comb begin
        eligible = '0;
        for (int r = 0; r < 2; r++) begin
            eligible[r] = rst_ni & ~flush_i & req_valid_i[r]
                        & (outst_q[r] < CW'(MAX_OUTST))
                        & ~busy_q[req_tid_i[r]];
        end
    end

    // Pick the winner and forward its operation. When both are eligible,
    // the requester that did not win last time is chosen.
    always_comb begin
        winner       = (&eligible) ? ~last_q : eligible[1];
        mult_valid_o = |eligible;
        mult_op_o    = req_op_i[winner];
        mult_a_o     = req_a_i[winner];
        mult_b_o     = req_b_i[winner];
        mult_tid_o   = req_tid_i[winner];
        issue        = mult_valid_o & mult_ready_i;
        req_ready_o  = '0;
        req_ready_o[winner] = issue;
        inc          = issue ? (winner ? 2'b10 : 2'b01) : 2'b00;
    end

    // Send each returning result to the owner of its trans_id. The data and
    // trans_id always pass straight through. Only the valid bit is steered.
    always_comb begin
        ret_hit     = mult_valid_i & busy_q[mult_tid_i];
        ret_owner   = owner_q[mult_tid_i];
        dec         = ret_hit ? (ret_owner ? 2'b10 : 2'b01) : 2'b00;
        res_valid_o = '0;
        if (ret_hit && !flush_i && rst_ni) begin
            res_valid_o[ret_owner] = 1'b1;
        end
        res_data_o  = mult_result_i;
        res_tid_o   = mult_tid_i;
        stray_o     = stray_q;
    end

    // Owner table, busy flags and per-requester counters. A return is applied
    // before an issue in the same cycle, so a tid that is freed and then
    // reissued ends up busy again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            owner_q <= '0;
            outst_q <= '0;
            last_q  <= 1'b1;
        end else if (flush_i) begin
            busy_q  <= '0;
            outst_q <= '0;
        end else begin
            if (ret_hit) begin
                busy_q[mult_tid_i] <= 1'b0;
            end
            if (issue) begin
                busy_q[mult_tid_o]  <= 1'b1;
                owner_q[mult_tid_o] <= winner;
                last_q              <= winner;
            end
            for (int r = 0; r < 2; r++) begin
                outst_q[r] <= outst_q[r] + CW'(inc[r]) - CW'(dec[r]);
            end
        end
    end

    // A result for a trans_id that nobody owns is recorded, and the flag
    // stays set until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stray_q <= 1'b0;
        end else if (mult_valid_i && !busy_q[mult_tid_i]) begin
            stray_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Eligibility should stop the counters from overflowing, and ownership
    // should stop them from underflowing.
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            for (int r = 0; r < 2; r++) begin
                assert (!(inc[r] && !dec[r] && outst_q[r] == CW'(MAX_OUTST)));
                assert (!(dec[r] && !inc[r] && outst_q[r] == '0));
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed table, hand-written corner sequences and a
// randomized run checked against an occupancy-map reference model.
module tb_mult_share_arb;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][6:0]  req_op_i;
    logic [1:0][63:0] req_a_i;
    logic [1:0][63:0] req_b_i;
    logic [1:0][2:0]  req_tid_i;
    logic             mult_valid_o;
    logic             mult_ready_i;
    logic [6:0]       mult_op_o;
    logic [63:0]      mult_a_o;
    logic [63:0]      mult_b_o;
    logic [2:0]       mult_tid_o;
    logic             mult_valid_i;
    logic [63:0]      mult_result_i;
    logic [2:0]       mult_tid_i;
    logic [1:0]       res_valid_o;
    logic [63:0]      res_data_o;
    logic [2:0]       res_tid_o;
    logic             stray_o;

    int n_checks = 0;
    int n_pass   = 0;

    mult_share_arb #(.XLEN(64), .OP_BITS(7), .TRANS_ID_BITS(3), .MAX_OUTST(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tid_i(req_tid_i),
        .mult_valid_o(mult_valid_o), .mult_ready_i(mult_ready_i),
        .mult_op_o(mult_op_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o), .mult_tid_o(mult_tid_o),
        .mult_valid_i(mult_valid_i), .mult_result_i(mult_result_i), .mult_tid_i(mult_tid_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_tid_o(res_tid_o),
        .stray_o(stray_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] rv;
        logic [2:0] t0;
        logic [2:0] t1;
        logic       rdy;
        logic       mv;
        logic [2:0] mt;
        logic       fl;
        logic       e_mv;
        logic [1:0] e_rr;
        logic [2:0] e_tid;
        logic [1:0] e_res;
        logic       e_stray;
    } vec_t;

    vec_t tbl[37];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic clearInputs();
        flush_i = 0; req_valid_i = 0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
        req_tid_i = '0; mult_ready_i = 0; mult_valid_i = 0; mult_result_i = '0; mult_tid_i = '0;
    endtask

    task automatic doReset();
        @(posedge clk_i); #1;
        clearInputs();
        rst_ni = 0;
        @(posedge clk_i); #1;
        rst_ni = 1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid_i   = v.rv;
        req_tid_i[0]  = v.t0;
        req_tid_i[1]  = v.t1;
        req_op_i[0]   = 7'($urandom);
        req_op_i[1]   = 7'($urandom);
        req_a_i[0]    = {$urandom, $urandom};
        req_a_i[1]    = {$urandom, $urandom};
        req_b_i[0]    = {$urandom, $urandom};
        req_b_i[1]    = {$urandom, $urandom};
        mult_ready_i  = v.rdy;
        mult_valid_i  = v.mv;
        mult_tid_i    = v.mt;
        mult_result_i = {$urandom, $urandom};
        flush_i       = v.fl;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        int w;
        w = v.e_rr[1] ? 1 : 0;
        check($sformatf("row%0d mult_valid", idx), 64'(mult_valid_o), 64'(v.e_mv));
        check($sformatf("row%0d req_ready", idx), 64'(req_ready_o), 64'(v.e_rr));
        if (v.e_mv) begin
            check($sformatf("row%0d mult_tid", idx), 64'(mult_tid_o), 64'(v.e_tid));
            check($sformatf("row%0d mult_a", idx), mult_a_o, req_a_i[w]);
            check($sformatf("row%0d mult_b", idx), mult_b_o, req_b_i[w]);
        end
        check($sformatf("row%0d res_valid", idx), 64'(res_valid_o), 64'(v.e_res));
        check($sformatf("row%0d res_data", idx), res_data_o, mult_result_i);
        check($sformatf("row%0d stray", idx), 64'(stray_o), 64'(v.e_stray));
    endtask

    // Reference model state: owner of each tid (-1 = free), sticky stray, last winner.
    int   owner_of[8];
    bit   stray_m;
    int   last_m;

    initial begin
        // rv,t0,t1,rdy,mv,mt,fl | e_mv,e_rr,e_tid,e_res,e_stray
        tbl[0]  = '{2'b01,3'd1,3'd0,1,0,3'd0,0, 1,2'b01,3'd1,2'b00,0};
        tbl[1]  = '{2'b00,3'd1,3'd0,1,1,3'd1,0, 0,2'b00,3'd0,2'b01,0};
        tbl[2]  = '{2'b11,3'd2,3'd3,1,0,3'd0,0, 1,2'b10,3'd3,2'b00,0};
        tbl[3]  = '{2'b11,3'd2,3'd4,1,0,3'd0,0, 1,2'b01,3'd2,2'b00,0};
        tbl[4]  = '{2'b11,3'd5,3'd4,1,0,3'd0,0, 1,2'b10,3'd4,2'b00,0};
        tbl[5]  = '{2'b11,3'd5,3'd6,1,0,3'd0,0, 1,2'b01,3'd5,2'b00,0};
        tbl[6]  = '{2'b00,3'd0,3'd0,1,1,3'd2,0, 0,2'b00,3'd0,2'b01,0};
        tbl[7]  = '{2'b00,3'd0,3'd0,1,1,3'd3,0, 0,2'b00,3'd0,2'b10,0};
        tbl[8]  = '{2'b00,3'd0,3'd0,1,1,3'd5,0, 0,2'b00,3'd0,2'b01,0};
        tbl[9]  = '{2'b00,3'd0,3'd0,1,1,3'd4,0, 0,2'b00,3'd0,2'b10,0};
        tbl[10] = '{2'b01,3'd2,3'd0,1,0,3'd0,0, 1,2'b01,3'd2,2'b00,0};
        tbl[11] = '{2'b10,3'd0,3'd3,1,0,3'd0,0, 1,2'b10,3'd3,2'b00,0};
        tbl[12] = '{2'b00,3'd0,3'd0,1,1,3'd3,0, 0,2'b00,3'd0,2'b10,0};
        tbl[13] = '{2'b00,3'd0,3'd0,1,1,3'd2,0, 0,2'b00,3'd0,2'b01,0};
        tbl[14] = '{2'b01,3'd1,3'd0,1,0,3'd0,0, 1,2'b01,3'd1,2'b00,0};
        tbl[15] = '{2'b10,3'd0,3'd1,1,0,3'd0,0, 0,2'b00,3'd0,2'b00,0};
        tbl[16] = '{2'b10,3'd0,3'd1,1,1,3'd1,0, 0,2'b00,3'd0,2'b01,0};
        tbl[17] = '{2'b10,3'd0,3'd1,1,0,3'd0,0, 1,2'b10,3'd1,2'b00,0};
        tbl[18] = '{2'b00,3'd0,3'd0,1,1,3'd1,0, 0,2'b00,3'd0,2'b10,0};
        tbl[19] = '{2'b01,3'd6,3'd0,0,0,3'd0,0, 1,2'b00,3'd6,2'b00,0};
        tbl[20] = '{2'b01,3'd6,3'd0,1,0,3'd0,0, 1,2'b01,3'd6,2'b00,0};
        tbl[21] = '{2'b00,3'd0,3'd0,1,1,3'd6,0, 0,2'b00,3'd0,2'b01,0};
        tbl[22] = '{2'b01,3'd0,3'd0,1,0,3'd0,0, 1,2'b01,3'd0,2'b00,0};
        tbl[23] = '{2'b01,3'd1,3'd0,1,0,3'd0,0, 1,2'b01,3'd1,2'b00,0};
        tbl[24] = '{2'b01,3'd2,3'd0,1,0,3'd0,0, 1,2'b01,3'd2,2'b00,0};
        tbl[25] = '{2'b01,3'd3,3'd0,1,0,3'd0,0, 1,2'b01,3'd3,2'b00,0};
        tbl[26] = '{2'b11,3'd4,3'd5,1,0,3'd0,0, 1,2'b10,3'd5,2'b00,0};
        tbl[27] = '{2'b01,3'd4,3'd0,1,0,3'd0,0, 0,2'b00,3'd0,2'b00,0};
        tbl[28] = '{2'b01,3'd4,3'd0,1,1,3'd0,0, 0,2'b00,3'd0,2'b01,0};
        tbl[29] = '{2'b01,3'd4,3'd0,1,0,3'd0,0, 1,2'b01,3'd4,2'b00,0};
        tbl[30] = '{2'b11,3'd6,3'd7,1,1,3'd1,1, 0,2'b00,3'd0,2'b00,0};
        tbl[31] = '{2'b01,3'd2,3'd0,1,0,3'd0,0, 1,2'b01,3'd2,2'b00,0};
        tbl[32] = '{2'b00,3'd0,3'd0,1,1,3'd2,0, 0,2'b00,3'd0,2'b01,0};
        tbl[33] = '{2'b00,3'd0,3'd0,1,1,3'd5,0, 0,2'b00,3'd0,2'b00,0};
        tbl[34] = '{2'b00,3'd0,3'd0,1,0,3'd0,0, 0,2'b00,3'd0,2'b00,1};
        tbl[35] = '{2'b10,3'd0,3'd7,1,0,3'd0,0, 1,2'b10,3'd7,2'b00,1};
        tbl[36] = '{2'b00,3'd1,3'd7,1,1,3'd7,0, 0,2'b00,3'd0,2'b10,1};

        // Outputs stay idle while reset is held, even with live requests.
        clearInputs();
        #2;
        req_valid_i = 2'b11; req_tid_i[0] = 3'd1; req_tid_i[1] = 3'd2;
        mult_ready_i = 1; mult_valid_i = 1; mult_tid_i = 3'd3;
        #1;
        check("reset mult_valid", 64'(mult_valid_o), 64'd0);
        check("reset req_ready", 64'(req_ready_o), 64'd0);
        check("reset res_valid", 64'(res_valid_o), 64'd0);
        check("reset stray", 64'(stray_o), 64'd0);
        clearInputs();
        @(posedge clk_i); #1;
        rst_ni = 1;

        // Directed table: round-robin, out-of-order returns, limits, flush, stray.
        for (int i = 0; i < 37; i++) begin
            applyStimulus(tbl[i]);
            #2;
            checkOutput(tbl[i], i);
            @(posedge clk_i); #1;
        end

        // Single multiply with known operands and product.
        doReset();
        req_valid_i = 2'b01; req_op_i[0] = 7'h01; req_tid_i[0] = 3'd1;
        req_a_i[0] = 64'h12345678; req_b_i[0] = 64'h12345678; mult_ready_i = 1;
        #2;
        check("single mult_valid", 64'(mult_valid_o), 64'd1);
        check("single mult_tid", 64'(mult_tid_o), 64'd1);
        check("single req_ready", 64'(req_ready_o), 64'b01);
        check("single mult_op", 64'(mult_op_o), 64'h01);
        check("single mult_a", mult_a_o, 64'h12345678);
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        mult_valid_i = 1; mult_tid_i = 3'd1; mult_result_i = 64'h014B66DC1DF4D840;
        #2;
        check("single res_valid", 64'(res_valid_o), 64'b01);
        check("single res_data", res_data_o, 64'h014B66DC1DF4D840);
        check("single res_tid", 64'(res_tid_o), 64'd1);
        @(posedge clk_i); #1;
        clearInputs();

        // Asynchronous reset in the middle of activity.
        req_valid_i = 2'b10; req_tid_i[1] = 3'd2; mult_ready_i = 1;
        @(posedge clk_i); #1;
        req_valid_i = 2'b00; mult_valid_i = 1; mult_tid_i = 3'd6;
        @(posedge clk_i); #1;
        check("midrst stray set", 64'(stray_o), 64'd1);
        req_valid_i = 2'b11; req_tid_i[0] = 3'd3; req_tid_i[1] = 3'd4;
        mult_valid_i = 1; mult_tid_i = 3'd2;
        #1;
        check("midrst res_valid before", 64'(res_valid_o), 64'b10);
        rst_ni = 0;
        #1;
        check("midrst mult_valid", 64'(mult_valid_o), 64'd0);
        check("midrst req_ready", 64'(req_ready_o), 64'd0);
        check("midrst res_valid", 64'(res_valid_o), 64'd0);
        check("midrst stray", 64'(stray_o), 64'd0);
        clearInputs();
        @(posedge clk_i); #1;
        rst_ni = 1;
        mult_valid_i = 1; mult_tid_i = 3'd2;
        #2;
        check("midrst dropped res", 64'(res_valid_o), 64'd0);
        @(posedge clk_i); #1;
        check("midrst dropped stray", 64'(stray_o), 64'd1);

        // Randomized run against the occupancy-map model.
        doReset();
        foreach (owner_of[k]) owner_of[k] = -1;
        stray_m = 0;
        last_m  = 1;
        for (int c = 0; c < 600; c++) begin
            int q[$];
            int cnt0, cnt1, w;
            bit el0, el1, e_mv, hit;
            logic [1:0] e_rr, e_res;
            req_valid_i = 2'($urandom);
            req_tid_i[0] = 3'($urandom_range(0, 7));
            req_tid_i[1] = 3'($urandom_range(0, 7));
            req_op_i[0] = 7'($urandom); req_op_i[1] = 7'($urandom);
            req_a_i[0] = {$urandom, $urandom}; req_a_i[1] = {$urandom, $urandom};
            req_b_i[0] = {$urandom, $urandom}; req_b_i[1] = {$urandom, $urandom};
            mult_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 29) == 0);
            mult_result_i = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) if (owner_of[k] >= 0) q.push_back(k);
            mult_valid_i = 0; mult_tid_i = '0;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                mult_valid_i = 1;
                mult_tid_i = 3'(q[$urandom_range(0, q.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                mult_valid_i = 1;
                mult_tid_i = 3'($urandom_range(0, 7));
            end

            cnt0 = 0; cnt1 = 0;
            foreach (owner_of[k]) begin
                if (owner_of[k] == 0) cnt0++;
                if (owner_of[k] == 1) cnt1++;
            end
            el0 = req_valid_i[0] && cnt0 < 4 && owner_of[req_tid_i[0]] < 0 && !flush_i;
            el1 = req_valid_i[1] && cnt1 < 4 && owner_of[req_tid_i[1]] < 0 && !flush_i;
            e_mv = el0 || el1;
            w = (el0 && el1) ? (1 - last_m) : (el1 ? 1 : 0);
            e_rr = (e_mv && mult_ready_i) ? (w == 1 ? 2'b10 : 2'b01) : 2'b00;
            hit = mult_valid_i && owner_of[mult_tid_i] >= 0;
            e_res = (hit && !flush_i) ? (owner_of[mult_tid_i] == 1 ? 2'b10 : 2'b01) : 2'b00;

            #2;
            check($sformatf("rnd%0d mult_valid", c), 64'(mult_valid_o), 64'(e_mv));
            check($sformatf("rnd%0d req_ready", c), 64'(req_ready_o), 64'(e_rr));
            if (e_mv) begin
                check($sformatf("rnd%0d mult_tid", c), 64'(mult_tid_o), 64'(req_tid_i[w]));
                check($sformatf("rnd%0d mult_op", c), 64'(mult_op_o), 64'(req_op_i[w]));
                check($sformatf("rnd%0d mult_a", c), mult_a_o, req_a_i[w]);
            end
            check($sformatf("rnd%0d res_valid", c), 64'(res_valid_o), 64'(e_res));
            check($sformatf("rnd%0d res_tid", c), 64'(res_tid_o), 64'(mult_tid_i));
            check($sformatf("rnd%0d stray", c), 64'(stray_o), 64'(stray_m));

            @(posedge clk_i);
            if (mult_valid_i && owner_of[mult_tid_i] < 0) stray_m = 1;
            if (flush_i) begin
                foreach (owner_of[k]) owner_of[k] = -1;
            end else begin
                if (hit) owner_of[mult_tid_i] = -1;
                if (e_mv && mult_ready_i) begin
                    owner_of[req_tid_i[w]] = w;
                    last_m = w;
                end
            end
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Two-port arbiter that shares the single integer multiply/divide unit between two issue requesters. Each accepted operation is forwarded with its trans_id to the shared unit. The owner of each in-flight trans_id is recorded, so out-of-order results (fixed-latency multiply overtaking a serial divide) are steered back to the correct requester. The block sits between the issue stage and the mult functional unit and shares its flush.

## Interface
Parameters:
- XLEN, 64, operand/result width
- OP_BITS, 7, width of the operator field
- TRANS_ID_BITS, 3, trans_id width; owner table depth = 2**TRANS_ID_BITS
- MAX_OUTST, 4, max in-flight ops per requester (1..2**TRANS_ID_BITS)

Ports (clock and reset first):
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush; also wired to the shared unit
- req_valid_i[1:0]  in  2  per-requester op valid
- req_ready_o[1:0]  out  2  per-requester accept
- req_op_i[r]  in  OP_BITS  operator
- req_a_i[r], req_b_i[r]  in  XLEN  operands
- req_tid_i[r]  in  TRANS_ID_BITS  trans_id
- mult_valid_o  out  1  op to shared unit
- mult_ready_i  in  1  shared unit accepts
- mult_op_o, mult_a_o, mult_b_o, mult_tid_o  out  OP_BITS/XLEN/XLEN/TRANS_ID_BITS  forwarded op
- mult_valid_i  in  1  result valid from unit
- mult_result_i  in  XLEN  result
- mult_tid_i  in  TRANS_ID_BITS  result trans_id
- res_valid_o[1:0]  out  2  per-requester result valid; single cycle, no backpressure
- res_data_o  out  XLEN  result, shared by both ports
- res_tid_o  out  TRANS_ID_BITS  result trans_id
- stray_o  out  1  sticky: a result arrived for an unowned trans_id

## Operation
- eligible[r] = req_valid_i[r] & (outst_q[r] < MAX_OUTST) & ~busy_q[req_tid_i[r]] & ~flush_i.
- Round-robin arbitration with pointer last_q (reset 1, so requester 0 wins first):
  - both eligible: pick ~last_q;
  - one eligible: pick that one.
- mult_valid_o = any eligible; mult_* muxed combinationally from the winner.
- req_ready_o[w] = mult_ready_i for the winner only; 0 for the loser.
- Issue fires on mult_valid_o & mult_ready_i. On issue:
  - busy_q[tid] <= 1;
  - owner_q[tid] <= w;
  - outst_q[w] increments;
  - last_q <= w.
- Return handling, when mult_valid_i and busy_q[mult_tid_i]:
  - res_valid_o[owner_q[tid]] = 1 combinationally, same cycle;
  - busy_q[tid] clears and outst_q[owner] decrements;
  - res_data_o = mult_result_i and res_tid_o = mult_tid_i always pass through.
- Return with busy_q clear: no res_valid_o; stray_o sets, cleared only by reset.
- Issue and return in the same cycle:
  - to the same requester, outst_q is unchanged;
  - to the same tid, the return clears first and the issue re-sets.
- outst_q counters are $clog2(MAX_OUTST+1) bits wide and never wrap. Saturation is prevented by eligibility; over- or underflow is an assertion failure.
- flush_i high:
  - clear all busy_q and outst_q on the next edge;
  - block all issue and suppress res_valid_o that cycle;
  - last_q holds.
  Results arriving after the flush for pre-flush tids count as stray only if the unit fails to flush; the bench treats that as an error.

## Timing
- Reset values: req_ready_o=0, mult_valid_o=0, res_valid_o=0, stray_o=0. Internal state: busy_q=0, outst_q=0, last_q=1.
- Request to mult_valid_o: 0 cycles, combinational. There is no buffering; requesters must hold operands stable until ready.
- Result to res_valid_o: 0 cycles.
- Table and counter updates are visible on the cycle after the edge.
- Reset asserted mid-operation clears all state immediately; in-flight results are then dropped as stray.

## Test plan
- Single op: req0 MUL a=0x12345678, b=0x12345678, tid=1, mult_ready_i=1 → same cycle mult_valid_o=1, mult_tid_o=1, req_ready_o=01. Unit returns 0x14B66DC1DF4D840 tid=1 → res_valid_o=01, res_data_o matches.
- Contention: both requesters valid every cycle, ready=1, distinct tids → grants alternate 0,1,0,1. Four back-to-back returns route by owner.
- Out-of-order: req0 DIV tid=2, then req1 MUL tid=3. MUL returns first → res_valid_o=10 (tid 3), then 01 (tid 2).
- Limits:
  - MAX_OUTST=4 ops in flight from req0 → 5th blocked (req_ready_o[0]=0) until a return; req1 still issues.
  - tid already busy → that request is blocked.
- Flush: 3 ops in flight, pulse flush_i → next cycle outst_q=0, busy_q=0, no res_valid_o during the flush. New op tid=2 is accepted on the following cycle.
- Stray: mult_valid_i with unowned tid=5 → res_valid_o=00, stray_o=1 and it stays set. Async reset mid-run → all outputs 0 immediately.
